// File: rtl/reg_file_param_pkg.sv
// Shared definitions for the parametrised register file: clear-sequencer
// state encoding, default geometry and the first-cleared-entry helper.
package reg_file_param_pkg;

  typedef enum logic {
    RF_ST_INIT = 1'b0,
    RF_ST_IDLE = 1'b1
  } rf_state_e;

  localparam int RF_DEF_DATA_WIDTH = 32;
  localparam int RF_DEF_ADDR_WIDTH = 5;

  // Entry 0 never needs clearing when it is hardwired to zero.
  function automatic int rf_first_entry(input int zero_reg);
    return (zero_reg != 0) ? 1 : 0;
  endfunction

endpackage

// File: rtl/reg_file_param_clr_seq.sv
// Clear sequencer: walks every clearable entry after reset or on request,
// and raises ready once the last entry has been zeroed.
module reg_file_param_clr_seq
  import reg_file_param_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  ready
);

  localparam logic [ADDR_WIDTH-1:0] FIRST = ADDR_WIDTH'(rf_first_entry(ZERO_REG));
  localparam logic [ADDR_WIDTH-1:0] LAST  = '1;

  rf_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;

  // State, counter and ready registers; reset restarts the clear from FIRST.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RF_ST_INIT;
      cnt_q   <= FIRST;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Next-state: advance the clear pointer in INIT, accept clear requests in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      RF_ST_INIT: begin
        if (cnt_q == LAST) begin
          state_d = RF_ST_IDLE;
          cnt_d   = FIRST;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      RF_ST_IDLE: begin
        if (clr_req) begin
          state_d = RF_ST_INIT;
          cnt_d   = FIRST;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = RF_ST_INIT;
        cnt_d   = FIRST;
        ready_d = 1'b0;
      end
    endcase
  end

  assign clr_we   = (state_q == RF_ST_INIT);
  assign clr_addr = cnt_q;
  assign ready    = ready_q;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised 2-read/1-write register file with optional hardwired-zero
// entry, optional write-to-read bypass and a hardware clear sequencer.
module reg_file_param
  import reg_file_param_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  input  logic                  clr_req,
  output logic                  ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  ready_w;

  logic                  user_we;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  reg_file_param_clr_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready_w)
  );

  assign ready = ready_w;

  // A user write lands only in IDLE and never on a hardwired-zero entry 0.
  assign user_we = ready_w && wen && !(ZR && (waddr == '0));

  // Write mux: the clear sequencer owns the port while it runs.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (user_we) begin
      mem_we = 1'b1;
    end
  end

  // Storage array; contents are initialised by the clear sequencer, not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read port 1: blanked during clear, zero entry, optional same-cycle bypass.
  always_comb begin
    rdata1 = mem_q[raddr1];
    if (!ready_w) begin
      rdata1 = '0;
    end else if (ZR && (raddr1 == '0)) begin
      rdata1 = '0;
    end else if (BP && user_we && (waddr == raddr1)) begin
      rdata1 = wdata;
    end
  end

  // Read port 2: same selection rules as port 1, evaluated independently.
  always_comb begin
    rdata2 = mem_q[raddr2];
    if (!ready_w) begin
      rdata2 = '0;
    end else if (ZR && (raddr2 == '0)) begin
      rdata2 = '0;
    end else if (BP && user_we && (waddr == raddr2)) begin
      rdata2 = wdata;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: one default build (zero reg + bypass) and one
// plain build (no zero reg, no bypass) driven with identical stimulus.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        clr_req;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        rdy_a, rdy_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  reg_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_a), .rdata2(rd2_a),
    .clr_req(clr_req), .ready(rdy_a)
  );

  reg_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_b), .rdata2(rd2_b),
    .clr_req(clr_req), .ready(rdy_b)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1a;
    logic [31:0] e2a;
    logic [31:0] e1b;
    logic [31:0] e2b;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until each build raises ready; 0 means it never rose.
  task automatic wait_ready(output int ca, output int cb, input bit drop_wen);
    ca = 0;
    cb = 0;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (ca == 0 && rdy_a) begin
        ca = n;
        if (drop_wen) wen = 1'b0;
      end
      if (cb == 0 && rdy_b) cb = n;
      if (drop_wen && n == 5) begin
        #1;
        chk("init_read_a", rd1_a, 32'h0);
        chk("init_read_b", rd1_b, 32'h0);
      end
      if (ca != 0 && cb != 0) break;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      #1;
      if (i != 0) chk($sformatf("%s_a[%0d]", tag, i), rd1_a, 32'h0);
      chk($sformatf("%s_b[%0d]", tag, i), rd1_b, 32'h0);
    end
  endtask

  logic [31:0] ma [32];
  logic [31:0] mb [32];

  initial begin
    int ca, cb;
    logic [31:0] ea1, ea2;

    vecs[0] = '{1'b1, 5'd5,  32'h000007D0, 5'd5,  5'd5,  32'h7D0,      32'h7D0,      32'h0,        32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'h7D0,      32'h0,        32'h7D0,      32'h0};
    vecs[2] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd9,  32'h12345678, 5'd9,  5'd5,  32'h12345678, 32'h7D0,      32'h0,        32'h7D0};
    vecs[5] = '{1'b1, 5'd9,  32'hCAFEF00D, 5'd9,  5'd9,  32'hCAFEF00D, 32'hCAFEF00D, 32'h12345678, 32'h12345678};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd31, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'h0};
    vecs[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd30, 5'd31, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h0};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd0,  32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 32'hDEADBEEF};

    rst = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
    raddr1 = 5'd1; raddr2 = 5'd2; clr_req = 1'b0;

    // Reset state and power-up clear length.
    step(); step(); step();
    chk("rst_ready_a", {31'b0, rdy_a}, 32'h0);
    chk("rst_ready_b", {31'b0, rdy_b}, 32'h0);
    chk("rst_rdata_a", rd1_a, 32'h0);
    rst = 1'b1;
    wait_ready(ca, cb, 1'b0);
    chk("boot_cycles_a", 32'(ca), 32'd31);
    chk("boot_cycles_b", 32'(cb), 32'd32);
    check_all_zero("boot");

    // Directed write/read/bypass/zero-register vectors.
    for (int i = 0; i < 9; i++) begin
      wen = vecs[i].wen; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      raddr1 = vecs[i].r1; raddr2 = vecs[i].r2;
      #2;
      chk($sformatf("vec%0d_r1_a", i), rd1_a, vecs[i].e1a);
      chk($sformatf("vec%0d_r2_a", i), rd2_a, vecs[i].e2a);
      chk($sformatf("vec%0d_r1_b", i), rd1_b, vecs[i].e1b);
      chk($sformatf("vec%0d_r2_b", i), rd2_b, vecs[i].e2b);
      step();
    end
    wen = 1'b0;

    // Fill, then clear on request with a write held throughout INIT.
    for (int i = 0; i < 32; i++) begin
      wen = 1'b1; waddr = 5'(i); wdata = $urandom | 32'h1;
      step();
    end
    wen = 1'b0;
    raddr1 = 5'd3;
    #1;
    chk("filled_b3_nonzero", {31'b0, (rd1_b != 32'h0)}, 32'h1);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    chk("clr_ready_drop_a", {31'b0, rdy_a}, 32'h0);
    chk("clr_ready_drop_b", {31'b0, rdy_b}, 32'h0);
    wen = 1'b1; waddr = 5'd3; wdata = 32'h55; raddr1 = 5'd3;
    wait_ready(ca, cb, 1'b1);
    wen = 1'b0;
    chk("clr_cycles_a", 32'(ca), 32'd31);
    chk("clr_cycles_b", 32'(cb), 32'd32);
    check_all_zero("clr");

    // Reset asserted ten cycles into a clear restarts it from the beginning.
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b0;
    #2;
    chk("midclr_rst_ready_a", {31'b0, rdy_a}, 32'h0);
    step(); step();
    rst = 1'b1;
    wait_ready(ca, cb, 1'b0);
    chk("restart_cycles_a", 32'(ca), 32'd31);
    chk("restart_cycles_b", 32'(cb), 32'd32);

    // Random regression against a behavioural model of both builds.
    for (int i = 0; i < 32; i++) begin
      ma[i] = 32'h0;
      mb[i] = 32'h0;
    end
    for (int c = 0; c < 2000; c++) begin
      wen   = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 31));
      wdata = $urandom;
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      if (raddr1 == 5'd0) ea1 = 32'h0;
      else if (wen && waddr == raddr1) ea1 = wdata;
      else ea1 = ma[raddr1];
      if (raddr2 == 5'd0) ea2 = 32'h0;
      else if (wen && waddr == raddr2) ea2 = wdata;
      else ea2 = ma[raddr2];
      #2;
      chk($sformatf("rnd%0d_r1_a", c), rd1_a, ea1);
      chk($sformatf("rnd%0d_r2_a", c), rd2_a, ea2);
      chk($sformatf("rnd%0d_r1_b", c), rd1_b, mb[raddr1]);
      chk($sformatf("rnd%0d_r2_b", c), rd2_b, mb[raddr2]);
      if (wen && waddr != 5'd0) ma[waddr] = wdata;
      if (wen) mb[waddr] = wdata;
      step();
    end
    wen = 1'b0;
    chk("rnd_ready_a", {31'b0, rdy_a}, 32'h1);
    chk("rnd_ready_b", {31'b0, rdy_b}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
